// File: rtl/debug_pkg.sv
// Shared command codes and state encodings for the single-step debug controller.
// Command bytes are ASCII so they can be typed from any serial terminal.
package debug_pkg;

   localparam logic [7:0] CMD_PULSE   = 8'h70;  // 'p'
   localparam logic [7:0] CMD_STEP    = 8'h73;  // 's'
   localparam logic [7:0] CMD_COUNT   = 8'h6E;  // 'n'
   localparam logic [7:0] CMD_ABORT   = 8'h78;  // 'x'
   localparam logic [7:0] CMD_CLR_ERR = 8'h65;  // 'e'

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARM_N = 2'd1,
      ST_STEP  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-clk data_valid strobe; deliberately has no reset.
// A start bit that is not still low at mid-bit is treated as a glitch, so the block self-recovers.
module uart_rx
   import debug_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rx,
   output logic [7:0] data,
   output logic       data_valid
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 2;
   localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] TICK_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   logic [1:0]    rx_meta;
   logic          rx_s;
   rx_state_t     rx_state;
   logic [CW-1:0] tick;
   logic [2:0]    bit_idx;
   logic [7:0]    shift;

   assign rx_s = rx_meta[1];

   always_ff @(posedge clk) begin
      rx_meta    <= {rx_meta[0], rx};
      data_valid <= 1'b0;
      case (rx_state)
         RX_IDLE: begin
            tick <= '0;
            if (!rx_s) rx_state <= RX_START;
         end
         RX_START: begin
            if (tick == TICK_HALF) begin
               tick     <= '0;
               bit_idx  <= 3'd0;
               rx_state <= rx_s ? RX_IDLE : RX_DATA;
            end else begin
               tick <= tick + 1'b1;
            end
         end
         RX_DATA: begin
            if (tick == TICK_LAST) begin
               tick    <= '0;
               shift   <= {rx_s, shift[7:1]};
               bit_idx <= bit_idx + 3'd1;
               if (bit_idx == 3'd7) rx_state <= RX_STOP;
            end else begin
               tick <= tick + 1'b1;
            end
         end
         RX_STOP: begin
            if (tick == TICK_LAST) begin
               tick     <= '0;
               rx_state <= RX_IDLE;
               if (rx_s) begin
                  data       <= shift;
                  data_valid <= 1'b1;
               end
            end else begin
               tick <= tick + 1'b1;
            end
         end
         default: rx_state <= RX_IDLE;
      endcase
   end

endmodule

// File: rtl/debug_step_ctrl.sv
// UART-commanded halt/resume pulser that can run the target for N Game Boy clock edges.
// trigger, busy and err are registered; trigger is never high on two consecutive clks.
module debug_step_ctrl
   import debug_pkg::*;
#(
   parameter int CNT_W         = 8,
   parameter int DEFAULT_STEPS = 4,
   parameter int SYNC_STAGES   = 2,
   parameter int CLKS_PER_BIT  = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx,
   input  logic halt,
   input  logic gb_clk,
   output logic trigger,
   output logic busy,
   output logic err
);

   localparam logic [CNT_W-1:0] STEPS_RST = CNT_W'(DEFAULT_STEPS);
   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

   logic [7:0]             rx_data;
   logic                   rx_valid;
   logic [SYNC_STAGES-1:0] gb_sync;
   logic                   gb_prev;
   logic                   edge_stb;
   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [CNT_W-1:0]       step_reg;
   logic [CNT_W-1:0]       new_steps;
   logic                   at_zero;

   uart_rx #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_uart_rx (
      .clk       (clk),
      .rx        (rx),
      .data      (rx_data),
      .data_valid(rx_valid)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         gb_sync <= '0;
         gb_prev <= 1'b0;
      end else begin
         gb_sync <= {gb_sync[SYNC_STAGES-2:0], gb_clk};
         gb_prev <= gb_sync[SYNC_STAGES-1];
      end
   end

   assign edge_stb  = gb_sync[SYNC_STAGES-1] & ~gb_prev;
   assign new_steps = (CNT_W'(rx_data) == '0) ? ONE : CNT_W'(rx_data);
   // A count that hits zero while the entry pulse is still high is held at zero
   // and completed one clk later, keeping trigger pulses apart.
   assign at_zero   = (cnt == '0) || (edge_stb && (cnt == ONE));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         step_reg <= STEPS_RST;
         trigger  <= 1'b0;
         busy     <= 1'b0;
         err      <= 1'b0;
      end else begin
         trigger <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (rx_valid) begin
                  case (rx_data)
                     CMD_PULSE: begin
                        if (trigger) err <= 1'b1;
                        else         trigger <= 1'b1;
                     end
                     CMD_STEP: begin
                        if (!halt || trigger) begin
                           err <= 1'b1;
                        end else begin
                           trigger <= 1'b1;
                           cnt     <= step_reg;
                           state   <= ST_STEP;
                           busy    <= 1'b1;
                        end
                     end
                     CMD_COUNT: begin
                        state <= ST_ARM_N;
                        busy  <= 1'b1;
                     end
                     CMD_CLR_ERR: err <= 1'b0;
                     default: ;
                  endcase
               end
            end
            ST_ARM_N: begin
               if (rx_valid) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  if (rx_data != CMD_ABORT) step_reg <= new_steps;
               end
            end
            ST_STEP: begin
               if (at_zero) begin
                  if (rx_valid) err <= 1'b1;
                  if (trigger) begin
                     cnt <= '0;
                  end else begin
                     trigger <= 1'b1;
                     cnt     <= '0;
                     state   <= ST_IDLE;
                     busy    <= 1'b0;
                  end
               end else begin
                  if (edge_stb) cnt <= cnt - ONE;
                  if (rx_valid) begin
                     case (rx_data)
                        CMD_PULSE: begin
                           if (trigger) begin
                              err <= 1'b1;
                           end else begin
                              trigger <= 1'b1;
                              cnt     <= '0;
                              state   <= ST_IDLE;
                              busy    <= 1'b0;
                           end
                        end
                        CMD_ABORT: begin
                           cnt   <= '0;
                           state <= ST_IDLE;
                           busy  <= 1'b0;
                        end
                        CMD_CLR_ERR: err <= 1'b0;
                        default:     err <= 1'b1;
                     endcase
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_debug_step_ctrl.sv
// Directed vector table plus hand sequences for step completion, coincident bytes and reset.
module tb_debug_step_ctrl;

   localparam int CPB = 16;

   logic clk    = 1'b0;
   logic rst_n  = 1'b0;
   logic rx     = 1'b1;
   logic halt   = 1'b0;
   logic gb_clk = 1'b0;
   logic trigger, busy, err;

   debug_step_ctrl #(
      .CNT_W(8), .DEFAULT_STEPS(4), .SYNC_STAGES(2), .CLKS_PER_BIT(CPB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx(rx), .halt(halt), .gb_clk(gb_clk),
      .trigger(trigger), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int   pc = 0;
   int   pulses = 0;
   int   consec = 0;
   int   last_trig_pc = -100;
   int   last_dv_pc = -100;
   int   n_chk = 0;
   int   n_pass = 0;
   logic trig_d = 1'b0;

   always @(posedge clk) pc++;

   always @(negedge clk) begin
      if (trigger) begin
         pulses++;
         last_trig_pc = pc;
         if (trig_d) consec++;
      end
      trig_d = trigger;
      if (dut.u_uart_rx.data_valid) last_dv_pc = pc;
   end

   typedef struct {
      logic [7:0] cmd;
      logic       halt;
      int         edges;
      int         exp_pulses;
      logic       exp_busy;
      logic       exp_err;
   } vec_t;

   vec_t vecs[20];

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx = 1'b0;
      tick_n(CPB);
      for (int k = 0; k < 8; k++) begin
         rx = b[k];
         tick_n(CPB);
      end
      rx = 1'b1;
      tick_n(CPB);
   endtask

   task automatic gb_edges(input int n);
      repeat (n) begin
         gb_clk = 1'b1;
         tick_n(3);
         gb_clk = 1'b0;
         tick_n(3);
      end
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   initial begin
      int p0, start_pc, lat_d;
      lat_d = 0;

      vecs[0]  = '{8'h70, 1'b0, 0, 1, 1'b0, 1'b0};  // p
      vecs[1]  = '{8'h73, 1'b1, 0, 1, 1'b1, 1'b0};  // s, enters STEP
      vecs[2]  = '{8'h78, 1'b1, 0, 0, 1'b0, 1'b0};  // x aborts
      vecs[3]  = '{8'h73, 1'b0, 0, 0, 1'b0, 1'b1};  // s while running
      vecs[4]  = '{8'h65, 1'b0, 0, 0, 1'b0, 1'b0};  // e
      vecs[5]  = '{8'h7A, 1'b0, 0, 0, 1'b0, 1'b0};  // unknown, ignored
      vecs[6]  = '{8'h6E, 1'b0, 0, 0, 1'b1, 1'b0};  // n
      vecs[7]  = '{8'h00, 1'b0, 0, 0, 1'b0, 1'b0};  // count 0 -> 1
      vecs[8]  = '{8'h73, 1'b1, 1, 2, 1'b0, 1'b0};  // one edge completes
      vecs[9]  = '{8'h6E, 1'b1, 0, 0, 1'b1, 1'b0};
      vecs[10] = '{8'h0A, 1'b1, 0, 0, 1'b0, 1'b0};  // count 10
      vecs[11] = '{8'h73, 1'b1, 9, 1, 1'b1, 1'b0};  // 9 of 10 edges
      vecs[12] = '{8'h71, 1'b1, 1, 1, 1'b0, 1'b1};  // q dropped, 10th edge completes
      vecs[13] = '{8'h65, 1'b1, 0, 0, 1'b0, 1'b0};
      vecs[14] = '{8'h73, 1'b1, 0, 1, 1'b1, 1'b0};
      vecs[15] = '{8'h70, 1'b1, 0, 1, 1'b0, 1'b0};  // p cancels step
      vecs[16] = '{8'h6E, 1'b1, 0, 0, 1'b1, 1'b0};
      vecs[17] = '{8'h78, 1'b1, 0, 0, 1'b0, 1'b0};  // x in ARM_N keeps count
      vecs[18] = '{8'h73, 1'b1, 9, 1, 1'b1, 1'b0};  // still 10 steps
      vecs[19] = '{8'h78, 1'b1, 0, 0, 1'b0, 1'b0};

      tick_n(4);
      check("reset trigger", int'(trigger), 0);
      check("reset busy", int'(busy), 0);
      check("reset err", int'(err), 0);
      rst_n = 1'b1;
      tick_n(25);

      for (int i = 0; i < 20; i++) begin
         p0       = pulses;
         halt     = vecs[i].halt;
         start_pc = pc;
         send_byte(vecs[i].cmd);
         if (i == 0) begin
            lat_d = last_dv_pc - start_pc;
            check("p latency", last_trig_pc - last_dv_pc, 1);
         end
         tick_n(4);
         gb_edges(vecs[i].edges);
         tick_n(6);
         check($sformatf("vec%0d pulses", i), pulses - p0, vecs[i].exp_pulses);
         check($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].exp_busy));
         check($sformatf("vec%0d err", i), int'(err), int'(vecs[i].exp_err));
      end

      // Default count of 4 after reset
      rst_n = 1'b0;
      tick_n(3);
      rst_n = 1'b1;
      tick_n(5);
      halt = 1'b1;
      p0   = pulses;
      send_byte(8'h73);
      tick_n(4);
      check("dflt entry pulse", pulses - p0, 1);
      check("dflt busy", int'(busy), 1);
      gb_edges(3);
      tick_n(6);
      check("dflt 3 edges pulses", pulses - p0, 1);
      check("dflt 3 edges busy", int'(busy), 1);
      gb_edges(1);
      tick_n(6);
      check("dflt 4 edges pulses", pulses - p0, 2);
      check("dflt 4 edges busy", int'(busy), 0);

      // Byte arrives in the same clk as the final edge strobe
      send_byte(8'h6E);
      send_byte(8'h01);
      send_byte(8'h73);
      tick_n(4);
      p0 = pulses;
      check("coinc busy before", int'(busy), 1);
      fork
         send_byte(8'h71);
         begin
            repeat (lat_d - 2) @(posedge clk);
            #1;
            gb_clk = 1'b1;
            tick_n(3);
            gb_clk = 1'b0;
         end
      join
      tick_n(6);
      check("coinc pulses", pulses - p0, 1);
      check("coinc aligned", last_trig_pc - last_dv_pc, 1);
      check("coinc err", int'(err), 1);
      check("coinc busy", int'(busy), 0);
      send_byte(8'h65);
      tick_n(4);
      check("coinc err cleared", int'(err), 0);

      // Reset in the middle of a step
      send_byte(8'h73);
      tick_n(4);
      check("rst mid busy before", int'(busy), 1);
      p0     = pulses;
      gb_clk = 1'b1;
      rst_n  = 1'b0;
      tick_n(3);
      check("rst mid trigger", int'(trigger), 0);
      check("rst mid busy", int'(busy), 0);
      check("rst mid err", int'(err), 0);
      rst_n = 1'b1;
      tick_n(10);
      gb_clk = 1'b0;
      tick_n(4);
      check("rst mid no pulse", pulses - p0, 0);
      check("rst mid busy after", int'(busy), 0);
      check("no back-to-back pulses", consec, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
